uart_rx_frame: RTL and testbench



---
 rtl/uart_rx_frame.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//   Parametrised UART receiver: 5..9 data bits (LSB first), optional odd/even
//   parity, 1 or 2 stop bits. Every bit is sampled three times around its
//   centre and decided by 2-of-3 majority. Short low glitches on an idle line
//   are rejected at the start bit. Parity, framing and break errors are
//   reported alongside each received word.
//
// Parameters
//   CLOCKS_PER_BIT  clocks per bit time (>= 4)
//   DATA_BITS       data bits per frame (5..9)
//   PARITY          0 = none, 1 = odd, 2 = even
//   STOP_BITS       1 or 2
//
// Ports
//   clock       in   single clock, all logic on posedge
//   reset       in   asynchronous, active-low
//   rx          in   serial line, asynchronous to clock, idles high
//   rxdata      out  last received data word
//   rxvalid     out  one-cycle pulse when rxdata and the error flags update
//   parity_err  out  parity mismatch in the last frame
//   frame_err   out  a stop bit was voted 0 in the last frame
//   break_det   out  last frame was all zeros including the stop bits
//   busy        out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLOCKS_PER_BIT = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rxdata,
  output logic                 rxvalid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int   C   = CLOCKS_PER_BIT;
  localparam int   H   = C / 2;
  localparam int   P   = (PARITY != 0) ? 1 : 0;
  localparam int   CW  = $clog2(C) + 1;
  localparam int   BW  = 4;
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic                 rx_meta;
  logic                 s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 v_a, v_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 all_zero;

  logic samp_a, samp_b, samp_c;
  logic vote;
  logic last_data, last_stop;
  logic frame_err_now, break_now, parity_bad;

  // Two-flop synchroniser; both stages reset to the idle (high) line level so
  // reset release never looks like a start edge.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      s       <= 1'b1;
    end else begin
      rx_meta <= rx;
      s       <= rx_meta;
    end
  end

  // cnt holds the position of the current cycle inside the current bit, so the
  // three samples sit at H-1, H and H+1 and the vote is formed on the last one.
  assign samp_a = (cnt == CW'(H - 1));
  assign samp_b = (cnt == CW'(H));
  assign samp_c = (cnt == CW'(H + 1));
  assign vote   = (v_a & v_b) | (v_a & s) | (v_b & s);

  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));

  // Evaluated on the vote of the last stop bit.
  assign frame_err_now = stop_err | ~vote;
  assign break_now     = all_zero & ~vote;
  assign parity_bad    = (P != 0) && ((^shreg ^ par_bit) != ODD);

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!s) state_next = START;
      START:     if (samp_c) state_next = vote ? IDLE : DATA;
      DATA:      if (samp_c && last_data) state_next = (P != 0) ? PAR : STOP;
      PAR:       if (samp_c) state_next = STOP;
      // Leave on the last stop vote rather than waiting out the bit, so a
      // back-to-back start edge is not missed.
      STOP:      if (samp_c && last_stop) state_next = frame_err_now ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      v_a        <= 1'b0;
      v_b        <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      all_zero   <= 1'b0;
      rxdata     <= '0;
      rxvalid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      rxvalid <= 1'b0;

      // The cycle that sees s == 0 in IDLE is frame cycle 0, so the counter
      // enters START already at 1.
      if (state == IDLE || state == WAIT_HIGH) begin
        cnt <= (state == IDLE && !s) ? CW'(1) : '0;
      end else begin
        cnt <= (cnt == CW'(C - 1)) ? '0 : cnt + CW'(1);
      end

      if (samp_a) v_a <= s;
      if (samp_b) v_b <= s;

      if (state == IDLE) begin
        bit_cnt  <= '0;
        stop_err <= 1'b0;
        all_zero <= 1'b1;
      end

      if (samp_c) begin
        unique case (state)
          DATA: begin
            shreg    <= {vote, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~vote;
            // Cleared on the last data bit so STOP starts counting from 0;
            // otherwise saturating, never wrapping inside a frame.
            if (last_data)          bit_cnt <= '0;
            else if (bit_cnt != '1) bit_cnt <= bit_cnt + BW'(1);
          end
          PAR: begin
            par_bit  <= vote;
            all_zero <= all_zero & ~vote;
          end
          STOP: begin
            stop_err <= stop_err | ~vote;
            all_zero <= all_zero & ~vote;
            if (last_stop) begin
              bit_cnt    <= '0;
              rxvalid    <= 1'b1;
              rxdata     <= break_now ? '0 : shreg;
              parity_err <= ~break_now & parity_bad;
              frame_err  <= frame_err_now;
              break_det  <= break_now;
            end else if (bit_cnt != '1) begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
//   Self-checking bench for uart_rx_frame. dut0 is 8N1, dut1 is 7 data bits
//   with even parity and one stop bit, both at 10 clocks per bit. Frames are
//   driven cycle by cycle from a bit vector; a monitor records every rxvalid
//   cycle together with the outputs present in that cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int C   = 10;
  // Drive cycle of the start edge to the rxvalid cycle: 2 synchroniser cycles
  // plus frame cycle L*C+H+2 = 9*10+5+2 = 97.
  localparam int LAT = 99;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx0   = 1'b1;
  logic       rx1   = 1'b1;

  logic [7:0] rxdata0;
  logic       rxvalid0, pe0, fe0, brk0, busy0;
  logic [6:0] rxdata1;
  logic       rxvalid1, pe1, fe1, brk1, busy1;

  uart_rx_frame #(
    .CLOCKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clock(clock), .reset(reset), .rx(rx0),
    .rxdata(rxdata0), .rxvalid(rxvalid0), .parity_err(pe0),
    .frame_err(fe0), .break_det(brk0), .busy(busy0)
  );

  uart_rx_frame #(
    .CLOCKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) dut1 (
    .clock(clock), .reset(reset), .rx(rx1),
    .rxdata(rxdata1), .rxvalid(rxvalid1), .parity_err(pe1),
    .frame_err(fe1), .break_det(brk1), .busy(busy1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // rxvalid monitor, sampled on the falling edge.
  int         vcnt  [2] = '{0, 0};
  int         vcyc  [2] = '{0, 0};
  logic [8:0] cdata [2];
  logic       cpe   [2];
  logic       cfe   [2];
  logic       cbrk  [2];

  always @(negedge clock) begin
    if (rxvalid0) begin
      vcnt[0]  <= vcnt[0] + 1;
      vcyc[0]  <= cyc;
      cdata[0] <= {1'b0, rxdata0};
      cpe[0]   <= pe0;
      cfe[0]   <= fe0;
      cbrk[0]  <= brk0;
    end
    if (rxvalid1) begin
      vcnt[1]  <= vcnt[1] + 1;
      vcyc[1]  <= cyc;
      cdata[1] <= {2'b00, rxdata1};
      cpe[1]   <= pe1;
      cfe[1]   <= fe1;
      cbrk[1]  <= brk1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives bits[0..nbits-1], C cycles each, on the selected line; the cycle at
  // index 'spike' is inverted; at most 'limit' cycles are driven.
  task automatic drive_frame(input logic sel, input logic [31:0] bits, input int nbits,
                             input int spike, input int limit, output int start);
    @(posedge clock);
    #1;
    start = cyc;
    for (int j = 0; j < nbits * C && j < limit; j++) begin
      logic b;
      b = bits[j / C] ^ (j == spike);
      if (sel) rx1 = b;
      else     rx0 = b;
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] frame_bits(input logic sel, input logic [8:0] data,
                                             input logic par, input logic stop);
    logic [31:0] b;
    b    = '1;
    b[0] = 1'b0;
    if (!sel) begin
      for (int i = 0; i < 8; i++) b[1 + i] = data[i];
      b[9] = stop;
    end else begin
      for (int i = 0; i < 7; i++) b[1 + i] = data[i];
      b[8] = par;
      b[9] = stop;
    end
    return b;
  endfunction

  task automatic check_frame(input string tag, input logic sel, input int start, input int cnt0,
                             input logic [8:0] ed, input logic epe, input logic efe,
                             input logic ebrk);
    check({tag, " pulses"},  vcnt[sel] - cnt0, 1);
    check({tag, " latency"}, vcyc[sel] - start, LAT);
    check({tag, " rxdata"},  cdata[sel], ed);
    check({tag, " par_err"}, cpe[sel], epe);
    check({tag, " frm_err"}, cfe[sel], efe);
    check({tag, " break"},   cbrk[sel], ebrk);
  endtask

  typedef struct {
    logic       sel;
    logic [8:0] data;
    logic       par;
    logic       stop;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_brk;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int st;
    int c0;
    int c1;
    logic [31:0] b;

    //            sel   data    par   stop  exp_data pe    fe    brk
    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 9'h081, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 9'h03C, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 9'h055, 1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 9'h040, 1'b0, 1'b1, 9'h040, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1};

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst rxdata",  rxdata0,  8'h00);
    check("rst rxvalid", rxvalid0, 1'b0);
    check("rst par_err", pe0,      1'b0);
    check("rst frm_err", fe0,      1'b0);
    check("rst break",   brk0,     1'b0);
    check("rst busy0",   busy0,    1'b0);
    check("rst busy1",   busy1,    1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(5);

    // Table-driven frames.
    for (int i = 0; i < 10; i++) begin
      c0 = vcnt[vecs[i].sel];
      b  = frame_bits(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop);
      drive_frame(vecs[i].sel, b, 10, -1, 1000, st);
      idle(20);
      check_frame($sformatf("vec%0d", i), vecs[i].sel, st, c0, vecs[i].exp_data,
                  vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_brk);
    end

    // Start glitch: 3 low cycles then high.
    c0 = vcnt[0];
    @(posedge clock);
    #1;
    st  = cyc;
    rx0 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rx0 = 1'b1;
    while (cyc < st + 5) @(negedge clock);
    check("glitch busy fc3", busy0, 1'b1);
    while (cyc < st + 9) @(negedge clock);
    check("glitch busy fc7", busy0, 1'b0);
    idle(30);
    check("glitch no valid", vcnt[0] - c0, 0);

    // Break: line low for 30 bit times.
    c0 = vcnt[0];
    drive_frame(1'b0, 32'h0, 30, -1, 1000, st);
    @(negedge clock);
    check("break busy low", busy0, 1'b1);
    rx0 = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("break busy high", busy0, 1'b0);
    check_frame("break", 1'b0, st, c0, 9'h000, 1'b0, 1'b1, 1'b1);
    idle(10);

    // Framing error with the line held low, then a clean frame.
    c0 = vcnt[0];
    b  = frame_bits(1'b0, 9'h03C, 1'b0, 1'b0);
    b[14:10] = 5'b00000;
    drive_frame(1'b0, b, 15, -1, 1000, st);
    @(negedge clock);
    check("ferr busy low", busy0, 1'b1);
    rx0 = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("ferr busy high", busy0, 1'b0);
    check_frame("ferr", 1'b0, st, c0, 9'h03C, 1'b0, 1'b1, 1'b0);
    idle(5);
    c0 = vcnt[0];
    drive_frame(1'b0, frame_bits(1'b0, 9'h081, 1'b0, 1'b1), 10, -1, 1000, st);
    idle(20);
    check_frame("after ferr", 1'b0, st, c0, 9'h081, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame, then a clean frame.
    c0 = vcnt[0];
    c1 = vcnt[1];
    drive_frame(1'b0, frame_bits(1'b0, 9'h0C3, 1'b0, 1'b1), 10, -1, 42, st);
    rx0   = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst rxdata0", rxdata0, 8'h00);
    check("midrst busy0",   busy0,   1'b0);
    check("midrst frm_err1", fe1,    1'b0);
    check("midrst break1",  brk1,    1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(20);
    drive_frame(1'b0, frame_bits(1'b0, 9'h03C, 1'b0, 1'b1), 10, -1, 1000, st);
    idle(20);
    check_frame("midrst", 1'b0, st, c0, 9'h03C, 1'b0, 1'b0, 1'b0);
    check("midrst dut1 valid", vcnt[1] - c1, 0);

    // One-cycle high spike at the centre sample of data bit 3 of 0x00.
    c0 = vcnt[0];
    drive_frame(1'b0, frame_bits(1'b0, 9'h000, 1'b0, 1'b1), 10, 4 * C + C / 2, 1000, st);
    idle(20);
    check_frame("spike", 1'b0, st, c0, 9'h000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
